// File: rtl/bingo_map_editor_if.sv
// Button pulses into the bingo map editor and the board/cursor state it
// exposes to the renderer.
interface bingo_map_editor_if;
  logic         btn_up;
  logic         btn_down;
  logic         btn_left;
  logic         btn_right;
  logic         btn_place;
  logic         btn_undo;
  logic         btn_fill;
  logic         btn_clear;
  logic         btn_lock;
  logic [124:0] map;
  logic [2:0]   cursor_x;
  logic [2:0]   cursor_y;
  logic [4:0]   next_value;
  logic         map_full;
  logic         busy;
  logic         locked;

  modport master (
    output btn_up, btn_down, btn_left, btn_right,
    output btn_place, btn_undo, btn_fill, btn_clear, btn_lock,
    input  map, cursor_x, cursor_y, next_value, map_full, busy, locked
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right,
    input  btn_place, btn_undo, btn_fill, btn_clear, btn_lock,
    output map, cursor_x, cursor_y, next_value, map_full, busy, locked
  );
endinterface

// File: rtl/bingo_map_editor.sv
// Edits the 5x5 bingo board: cursor, manual placement with undo history,
// one-cell-per-cycle auto-fill, and a lock that freezes a full board.
module bingo_map_editor (
  input  logic              clk_25MHz,
  input  logic              all_rst,
  bingo_map_editor_if.slave bus
);

  typedef enum logic [1:0] {EDIT, FILL, LOCKED} state_t;

  state_t       r_state;
  logic [124:0] r_map;
  logic [2:0]   r_cursorX;
  logic [2:0]   r_cursorY;
  logic [4:0]   r_nextValue;
  logic [4:0]   r_scanIdx;
  logic [4:0]   r_hist [0:24];
  logic         r_full;
  logic         r_busy;
  logic         r_locked;

  logic [4:0]   w_cursorIdx;
  logic [4:0]   w_cursorCell;
  logic [4:0]   w_scanCell;
  logic [4:0]   w_undoPos;
  logic [4:0]   w_undoIdx;
  logic [2:0]   w_nextX;
  logic [2:0]   w_nextY;

  assign w_cursorIdx  = 5'(r_cursorX) + 5'(r_cursorY) * 5'd5;
  assign w_cursorCell = r_map[5*w_cursorIdx +: 5];
  assign w_scanCell   = r_map[5*r_scanIdx +: 5];
  assign w_undoPos    = (r_nextValue > 5'd1) ? (r_nextValue - 5'd2) : 5'd0;
  assign w_undoIdx    = r_hist[w_undoPos];

  // Opposing pulses on one axis cancel; each axis wraps around 0..4.
  always_comb begin
    w_nextX = r_cursorX;
    w_nextY = r_cursorY;
    if (bus.btn_left && !bus.btn_right)
      w_nextX = (r_cursorX == 3'd0) ? 3'd4 : r_cursorX - 3'd1;
    else if (bus.btn_right && !bus.btn_left)
      w_nextX = (r_cursorX == 3'd4) ? 3'd0 : r_cursorX + 3'd1;
    if (bus.btn_up && !bus.btn_down)
      w_nextY = (r_cursorY == 3'd0) ? 3'd4 : r_cursorY - 3'd1;
    else if (bus.btn_down && !bus.btn_up)
      w_nextY = (r_cursorY == 3'd4) ? 3'd0 : r_cursorY + 3'd1;
  end

  always_ff @(posedge clk_25MHz) begin
    if (!all_rst) begin
      r_state     <= EDIT;
      r_map       <= '0;
      r_cursorX   <= '0;
      r_cursorY   <= '0;
      r_nextValue <= 5'd1;
      r_scanIdx   <= '0;
      r_full      <= 1'b0;
      r_busy      <= 1'b0;
      r_locked    <= 1'b0;
      for (int i = 0; i < 25; i++) r_hist[i] <= '0;
    end else begin
      case (r_state)
        EDIT: begin
          r_cursorX <= w_nextX;
          r_cursorY <= w_nextY;
          if (bus.btn_clear) begin
            r_map       <= '0;
            r_nextValue <= 5'd1;
            r_full      <= 1'b0;
          end else if (bus.btn_fill) begin
            r_state   <= FILL;
            r_scanIdx <= '0;
            r_busy    <= 1'b1;
          end else if (bus.btn_undo) begin
            if (r_nextValue > 5'd1) begin
              r_map[5*w_undoIdx +: 5] <= '0;
              r_nextValue             <= r_nextValue - 5'd1;
              r_full                  <= 1'b0;
            end
          end else if (bus.btn_place) begin
            if (w_cursorCell == 5'd0 && r_nextValue <= 5'd25) begin
              r_map[5*w_cursorIdx +: 5]   <= r_nextValue;
              r_hist[r_nextValue - 5'd1]  <= w_cursorIdx;
              r_nextValue                 <= r_nextValue + 5'd1;
              r_full                      <= (r_nextValue == 5'd25);
            end
          end else if (bus.btn_lock) begin
            if (r_full) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end
          end
        end

        // The scan always walks all 25 cells, so busy lasts 25 cycles even on a full board.
        FILL: begin
          if (bus.btn_clear) begin
            r_map       <= '0;
            r_nextValue <= 5'd1;
            r_full      <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= EDIT;
          end else begin
            if (w_scanCell == 5'd0 && r_nextValue <= 5'd25) begin
              r_map[5*r_scanIdx +: 5]    <= r_nextValue;
              r_hist[r_nextValue - 5'd1] <= r_scanIdx;
              r_nextValue                <= r_nextValue + 5'd1;
              r_full                     <= (r_nextValue == 5'd25);
            end
            if (r_scanIdx == 5'd24) begin
              r_state <= EDIT;
              r_busy  <= 1'b0;
            end else begin
              r_scanIdx <= r_scanIdx + 5'd1;
            end
          end
        end

        LOCKED: begin
          if (bus.btn_clear) begin
            r_map       <= '0;
            r_nextValue <= 5'd1;
            r_full      <= 1'b0;
            r_locked    <= 1'b0;
            r_state     <= EDIT;
          end
        end

        default: r_state <= EDIT;
      endcase
    end
  end

  assign bus.map        = r_map;
  assign bus.cursor_x   = r_cursorX;
  assign bus.cursor_y   = r_cursorY;
  assign bus.next_value = r_nextValue;
  assign bus.map_full   = r_full;
  assign bus.busy       = r_busy;
  assign bus.locked     = r_locked;

endmodule
